// File: rtl/sprite_ram_loader_if.sv
// Byte-stream and RAM write-port bundle for the sprite RAM loader.
// The master side is the loader itself: it accepts bytes from the host
// bridge and drives the RAM write port. The slave side is the host
// bridge plus the RAM it feeds.
interface sprite_ram_loader_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic [ADDR_W-1:0] write_address;
    logic [PIX_W-1:0]  data_In;
    logic              we;

    modport master (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output write_address,
        output data_In,
        output we
    );

    modport slave (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  write_address,
        input  data_In,
        input  we
    );
endinterface

// File: rtl/sprite_ram_loader.sv
// Write-side master for the 4-bit palette-index sprite/background RAMs.
// Each accepted byte is unpacked into two pixels (high nibble first) and
// written to consecutive RAM addresses inside a window that is checked
// against the RAM depth before any write is issued.
// All outputs come straight from flops; they are computed from the next
// state so they line up with the state they belong to.
module sprite_ram_loader #(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 69520,
    parameter int PIX_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_pixels,
    sprite_ram_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WR_HI = 3'd3,
        ST_WR_LO = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // Window end is compared two bits wider than an address so that
    // base + count can never overflow before the comparison.
    localparam logic [ADDR_W+1:0] DEPTH_LIM = (ADDR_W+2)'(DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   REM_ZERO  = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] cur_addr_r, cur_addr_s;
    logic [ADDR_W:0]   remaining_r, remaining_s;
    logic [7:0]        byte_r, byte_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [PIX_W-1:0]  wr_data_r, wr_data_s;
    logic              we_r, we_s;
    logic              in_ready_r, in_ready_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              error_r, error_s;
    logic [ADDR_W+1:0] win_end_s;

    assign win_end_s = {2'b00, cur_addr_r} + {1'b0, remaining_r};

    // Next-state and next-output logic for the load sequencer.
    always_comb begin
        state_s     = state_r;
        cur_addr_s  = cur_addr_r;
        remaining_s = remaining_r;
        byte_s      = byte_r;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        we_s        = 1'b0;
        error_s     = error_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_s  = base_addr;
                    remaining_s = num_pixels;
                    error_s     = 1'b0;
                    state_s     = ST_CHECK;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (win_end_s > DEPTH_LIM) begin
                    error_s = 1'b1;
                    state_s = ST_FIN;
                end else if (remaining_r == REM_ZERO) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // in_ready is high for the whole of this state, so a valid
                // byte here is a completed handshake.
                if (bus.in_valid) begin
                    byte_s    = bus.in_byte;
                    we_s      = 1'b1;
                    wr_addr_s = cur_addr_r;
                    wr_data_s = bus.in_byte[7:4];
                    state_s   = ST_WR_HI;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WR_HI: begin
                cur_addr_s  = cur_addr_r + ADDR_ONE;
                remaining_s = remaining_r - REM_ONE;
                if (remaining_r == REM_ONE) begin
                    // Odd pixel count: the low nibble of the last byte is dropped.
                    state_s = ST_FIN;
                end else begin
                    we_s      = 1'b1;
                    wr_addr_s = cur_addr_r + ADDR_ONE;
                    wr_data_s = byte_r[3:0];
                    state_s   = ST_WR_LO;
                end
            end
            ST_WR_LO: begin
                cur_addr_s  = cur_addr_r + ADDR_ONE;
                remaining_s = remaining_r - REM_ONE;
                if (remaining_r == REM_ONE) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        in_ready_s = (state_s == ST_WAIT);
        busy_s     = (state_s != ST_IDLE);
        done_s     = (state_s == ST_FIN);
    end

    // State, datapath and output registers; reset aborts any load at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            cur_addr_r  <= '0;
            remaining_r <= '0;
            byte_r      <= 8'h00;
            wr_addr_r   <= '0;
            wr_data_r   <= '0;
            we_r        <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cur_addr_r  <= cur_addr_s;
            remaining_r <= remaining_s;
            byte_r      <= byte_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            we_r        <= we_s;
            in_ready_r  <= in_ready_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            error_r     <= error_s;
        end
    end

    assign bus.in_ready      = in_ready_r;
    assign bus.write_address = wr_addr_r;
    assign bus.data_In       = wr_data_r;
    assign bus.we            = we_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign error             = error_r;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Randomized self-checking bench for sprite_ram_loader. A reference model
// derives the expected (address, pixel) list straight from base, count and
// the byte stream; a second instance with a small depth feeds a RAM model
// that is read back through a registered read port.
module tb_sprite_ram_loader;
    localparam int ADDR_W = 17;
    localparam int DEPTH  = 69520;
    localparam int DEPTH2 = 2304;

    typedef logic [7:0] byte_q_t[$];

    logic              Clk = 1'b0;
    logic              Reset;
    logic              start, start2;
    logic [ADDR_W-1:0] base_addr, base_addr2;
    logic [ADDR_W:0]   num_pixels, num_pixels2;
    logic              busy, done, error;
    logic              busy2, done2, error2;
    logic [11:0]       read_address;
    logic [3:0]        data_Out;
    logic [3:0]        ram2 [0:DEPTH2-1];

    int total = 0;
    int bad   = 0;
    byte_q_t bq;

    sprite_ram_loader_if #(.ADDR_W(ADDR_W), .PIX_W(4)) ifc ();
    sprite_ram_loader_if #(.ADDR_W(ADDR_W), .PIX_W(4)) if2 ();

    sprite_ram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PIX_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
        .num_pixels(num_pixels), .bus(ifc), .busy(busy), .done(done), .error(error)
    );

    sprite_ram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH2), .PIX_W(4)) dut2 (
        .Clk(Clk), .Reset(Reset), .start(start2), .base_addr(base_addr2),
        .num_pixels(num_pixels2), .bus(if2), .busy(busy2), .done(done2), .error(error2)
    );

    always #5 Clk = ~Clk;

    // Small-depth RAM model: synchronous write, registered read.
    always @(posedge Clk) begin
        if (if2.we) ram2[if2.write_address[11:0]] <= if2.data_In;
        data_Out <= ram2[read_address];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic fill_rand(input int n);
        bq.delete();
        for (int i = 0; i < (n + 1) / 2; i++) bq.push_back(8'($urandom));
    endtask

    // One complete load on the main instance, checked against the model.
    task automatic run_load(input string name, input int base, input int n,
                            input byte_q_t bytes, input int gap_pct, input bit restart);
        int exp_a[$]; int exp_d[$]; int obs_a[$]; int obs_d[$];
        int cyc, dones, hs, idx, first_we, done_cyc, nchk;
        bit exp_err;
        logic [7:0] b;
        exp_err = (base + n > DEPTH);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                b = bytes[i / 2];
                exp_a.push_back(base + i);
                exp_d.push_back((i % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]));
            end
        end
        @(negedge Clk);
        start = 1'b1; base_addr = ADDR_W'(base); num_pixels = (ADDR_W+1)'(n);
        ifc.in_valid = 1'b0;
        @(negedge Clk);
        start = 1'b0;
        cyc = 0; dones = 0; hs = 0; idx = 0; first_we = -1; done_cyc = -1;
        while (dones == 0 && cyc < 3000) begin
            if (ifc.we) begin
                obs_a.push_back(int'(ifc.write_address));
                obs_d.push_back(int'(ifc.data_In));
                if (first_we < 0) first_we = cyc;
            end
            if (ifc.in_ready) check_val({name, "_rdy_state"}, {62'd0, ifc.we, busy}, 64'd1);
            if (done) begin
                dones++;
                done_cyc = cyc;
                check_val({name, "_err_at_done"}, error, exp_err);
            end
            ifc.in_valid = (idx < bytes.size()) && (int'($urandom_range(99)) >= gap_pct);
            ifc.in_byte  = ifc.in_valid ? bytes[idx] : 8'($urandom);
            if (ifc.in_valid && ifc.in_ready) begin
                idx++;
                hs++;
            end
            if (restart && cyc == 3) begin
                start = 1'b1; base_addr = ADDR_W'(base + 7); num_pixels = (ADDR_W+1)'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge Clk);
            cyc++;
        end
        start = 1'b0;
        ifc.in_valid = 1'b0;
        check_val({name, "_done_seen"}, dones, 1);
        check_val({name, "_idle_after"}, {60'd0, done, busy, ifc.we, ifc.in_ready}, 64'd0);
        check_val({name, "_err_sticky"}, error, exp_err);
        check_val({name, "_handshakes"}, hs, exp_err ? 0 : (n + 1) / 2);
        check_val({name, "_nwrites"}, obs_a.size(), exp_a.size());
        nchk = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int i = 0; i < nchk; i++) begin
            check_val($sformatf("%s_addr%0d", name, i), obs_a[i], exp_a[i]);
            check_val($sformatf("%s_data%0d", name, i), obs_d[i], exp_d[i]);
        end
        if (gap_pct == 0) begin
            if (exp_a.size() > 0) check_val({name, "_first_we_lat"}, first_we, 2);
            else                  check_val({name, "_done_lat"}, done_cyc, 1);
        end
    endtask

    initial begin
        int cyc, idx, seen, base, n, wes;
        Reset = 1'b1; start = 1'b0; start2 = 1'b0;
        base_addr = '0; num_pixels = '0; base_addr2 = '0; num_pixels2 = '0;
        ifc.in_valid = 1'b0; ifc.in_byte = 8'h00;
        if2.in_valid = 1'b0; if2.in_byte = 8'h00;
        read_address = 12'd0;
        repeat (3) @(negedge Clk);
        check_val("reset_state", {ifc.we, ifc.in_ready, busy, done, error}, 64'd0);
        check_val("reset_addr_data", {ifc.write_address, ifc.data_In}, 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        bq.delete(); bq.push_back(8'hA5); bq.push_back(8'h3C);
        run_load("t2_even", 100, 4, bq, 0, 1'b0);
        bq.delete(); bq.push_back(8'h12); bq.push_back(8'h34);
        run_load("t3_odd", 0, 3, bq, 0, 1'b0);
        bq.delete();
        run_load("t4_zero", 500, 0, bq, 0, 1'b0);
        fill_rand(21);
        run_load("t4_oor", 69500, 21, bq, 0, 1'b0);
        fill_rand(20);
        run_load("t4_edge", 69500, 20, bq, 0, 1'b0);
        bq.delete(); bq.push_back(8'hA5); bq.push_back(8'h3C);
        run_load("t5_bp", 100, 4, bq, 50, 1'b1);

        for (int k = 0; k < 8; k++) begin
            base = (k % 2 == 1) ? DEPTH - int'($urandom_range(1, 30)) : int'($urandom_range(DEPTH - 1));
            n = int'($urandom_range(40));
            fill_rand(n);
            run_load($sformatf("rnd%0d", k), base, n, bq, int'($urandom_range(60)), k[0]);
        end

        // Reset in the middle of the low-nibble write of the first byte.
        fill_rand(4);
        @(negedge Clk);
        start = 1'b1; base_addr = ADDR_W'(200); num_pixels = (ADDR_W+1)'(4);
        @(negedge Clk);
        start = 1'b0; ifc.in_valid = 1'b1; ifc.in_byte = bq[0];
        seen = 0;
        for (cyc = 0; cyc < 20 && seen == 0; cyc++) begin
            @(negedge Clk);
            if (ifc.we && ifc.write_address == ADDR_W'(201)) seen = 1;
        end
        check_val("t1_reached_wr_lo", seen, 1);
        Reset = 1'b1;
        #1;
        check_val("t1_outs_zero", {ifc.we, ifc.in_ready, busy, done, error}, 64'd0);
        check_val("t1_addr_data_zero", {ifc.write_address, ifc.data_In}, 64'd0);
        ifc.in_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        wes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            wes += int'(busy) + int'(done) + int'(ifc.we);
        end
        check_val("t1_stays_idle", wes, 0);

        // Second instance: 64 pixels into a 2304-word RAM, then read back.
        fill_rand(64);
        @(negedge Clk);
        start2 = 1'b1; base_addr2 = ADDR_W'(1000); num_pixels2 = (ADDR_W+1)'(64);
        @(negedge Clk);
        start2 = 1'b0; idx = 0; seen = 0;
        for (cyc = 0; cyc < 1000 && seen == 0; cyc++) begin
            if (done2) seen = 1;
            if2.in_valid = (idx < 32);
            if2.in_byte  = (idx < 32) ? bq[idx] : 8'h00;
            if (if2.in_valid && if2.in_ready) idx++;
            @(negedge Clk);
        end
        if2.in_valid = 1'b0;
        check_val("t6_done", seen, 1);
        check_val("t6_err", error2, 0);
        for (int i = 0; i < 64; i++) begin
            read_address = 12'(1000 + i);
            @(negedge Clk);
            check_val($sformatf("t6_rd%0d", i), data_Out,
                      (i % 2 == 0) ? 64'(bq[i / 2][7:4]) : 64'(bq[i / 2][3:0]));
        end

        // Window one past the end of the small RAM must be rejected.
        @(negedge Clk);
        start2 = 1'b1; base_addr2 = ADDR_W'(2300); num_pixels2 = (ADDR_W+1)'(5);
        @(negedge Clk);
        start2 = 1'b0; seen = 0; wes = 0;
        for (cyc = 0; cyc < 20 && seen == 0; cyc++) begin
            if (done2) seen = 1;
            wes += int'(if2.we);
            @(negedge Clk);
        end
        check_val("t6_oor_done", seen, 1);
        check_val("t6_oor_err", error2, 1);
        check_val("t6_oor_no_we", wes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
